sint_window_accumulator: RTL and testbench

//  Downstream consumer of the SInt[WIDTH] add stage: takes its signed sum on a valid/ready stream,

---
 rtl/sint_window_accumulator.sv | 171 +++++++++++++++++
 tb/tb_sint_window_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sint_window_accumulator.sv
// sint_window_accumulator: sums COUNT signed samples per window and emits the
// window total on a valid/ready stream.
//
// Optional feature macro: SINT_ACC_SAT_EN
//   defined   -> accumulator and out_data clamp to the signed range on overflow
//   undefined -> accumulator and out_data wrap (two's complement) to ACC_WIDTH
//
// Ports:
//   CLK         in   rising-edge clock
//   ASYNCRESET  in   asynchronous active-high reset
//   in_valid    in   in_data valid
//   in_ready    out  block accepts in_data this cycle
//   in_data     in   [WIDTH-1:0] signed sample
//   out_valid   out  out_data/out_ovf hold a completed window
//   out_ready   in   sink accepts the output this cycle
//   out_data    out  [ACC_WIDTH-1:0] signed window total
//   out_ovf     out  accumulator left the signed range during the window

module sint_window_accumulator #(
    parameter int WIDTH     = 3,
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic                 ovf;
    logic                 ovf_n;
    logic                 out_valid_n;
    logic [ACC_WIDTH-1:0] out_data_n;
    logic                 out_ovf_n;

    logic [ACC_WIDTH:0]   sample_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 overflow;
    logic [ACC_WIDTH-1:0] sum_fit;
    logic [ACC_WIDTH-1:0] load_val;
    logic                 in_acc;
    logic                 out_acc;
    logic                 last;

    // One guard bit above the accumulator: two in-range operands can
    // never overflow at ACC_WIDTH+1, so the top two bits disagreeing
    // is exactly the out-of-range condition.
    assign sample_ext = {{(ACC_WIDTH+1-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign sum        = {acc[ACC_WIDTH-1], acc} + sample_ext;
    assign overflow   = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

`ifdef SINT_ACC_SAT_EN
    assign sum_fit = overflow ?
                     (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) :
                     sum[ACC_WIDTH-1:0];
`else
    assign sum_fit = sum[ACC_WIDTH-1:0];
`endif

    // First sample of a window lands in an empty accumulator; it
    // always fits because ACC_WIDTH >= WIDTH.
    assign load_val = sample_ext[ACC_WIDTH-1:0];

    assign last    = (cnt == CNT_LAST);
    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_ovf   <= out_ovf_n;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        ovf_n       = ovf;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_ovf_n   = out_ovf;
        in_ready    = 1'b1;

        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_acc) begin
                    if (!last) begin
                        acc_n = sum_fit;
                        cnt_n = cnt + CW'(1);
                        ovf_n = ovf | overflow;
                    end else begin
                        out_data_n  = sum_fit;
                        out_ovf_n   = ovf | overflow;
                        out_valid_n = 1'b1;
                        acc_n       = '0;
                        cnt_n       = '0;
                        ovf_n       = 1'b0;
                        state_n     = HOLD;
                    end
                end
            end

            HOLD: begin
                // Pass-through readiness: a new sample is taken only
                // in the cycle the held result leaves.
                in_ready = out_ready;
                if (out_acc && !in_acc) begin
                    out_valid_n = 1'b0;
                    state_n     = ACCUM;
                end else if (out_acc && in_acc) begin
                    if (COUNT == 1) begin
                        // Single-sample windows complete immediately.
                        out_data_n = load_val;
                        out_ovf_n  = 1'b0;
                    end else begin
                        acc_n       = load_val;
                        cnt_n       = CW'(1);
                        ovf_n       = 1'b0;
                        out_valid_n = 1'b0;
                        state_n     = ACCUM;
                    end
                end
            end

            default: begin
                state_n = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_sint_window_accumulator.sv
// tb_sint_window_accumulator: directed test of sint_window_accumulator in
// default, narrow-accumulator and single-sample-window configurations.

module tb_sint_window_accumulator;

    logic       CLK;
    logic       ASYNCRESET;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [2:0] a_in_data;
    logic [7:0] a_out_data;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [2:0] b_in_data;
    logic [3:0] b_out_data;

    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [2:0] c_in_data;
    logic [7:0] c_out_data;

    int vectors;
    int miscompares;

    sint_window_accumulator dut_a (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .out_ovf    (a_out_ovf)
    );

    sint_window_accumulator #(.ACC_WIDTH(4)) dut_b (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .out_ovf    (b_out_ovf)
    );

    sint_window_accumulator #(.COUNT(1)) dut_c (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .in_valid   (c_in_valid),
        .in_ready   (c_in_ready),
        .in_data    (c_in_data),
        .out_valid  (c_out_valid),
        .out_ready  (c_out_ready),
        .out_data   (c_out_data),
        .out_ovf    (c_out_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] samp [8];
    int         k;
    int         nout;
    int         cyc;
    logic       took;

    initial begin
        vectors     = 0;
        miscompares = 0;
        ASYNCRESET  = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;

        // Reset takes effect with no clock edge.
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("rst_out_data",  {24'd0, a_out_data},  32'h00);
        chk("rst_out_ovf",   {31'd0, a_out_ovf},   32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1 ASYNCRESET = 1'b0;

        // Basic window 1,2,-3,3 = 3.
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data = 3'd1;    tick();
        a_in_data = 3'd2;    tick();
        a_in_data = 3'b101;  tick();
        a_in_data = 3'd3;    tick();
        chk("w1_valid", {31'd0, a_out_valid}, 32'd1);
        chk("w1_data",  {24'd0, a_out_data},  32'h03);
        chk("w1_ovf",   {31'd0, a_out_ovf},   32'd0);
        chk("w1_ready", {31'd0, a_in_ready},  32'd1);

        // Back-to-back window 2,1,1,1 = 5, first sample overlaps output.
        a_in_data = 3'd2;    tick();
        chk("w2_drain", {31'd0, a_out_valid}, 32'd0);
        a_in_data = 3'd1;    tick();
        tick();
        tick();
        chk("w2_valid", {31'd0, a_out_valid}, 32'd1);
        chk("w2_data",  {24'd0, a_out_data},  32'h05);

        // Backpressure: -4 x4 = -16 held while out_ready=0.
        a_in_valid = 1'b0;   tick();
        chk("bp_idle", {31'd0, a_out_valid}, 32'd0);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 3'b100;
        tick(); tick(); tick(); tick();
        chk("bp_valid", {31'd0, a_out_valid}, 32'd1);
        chk("bp_data",  {24'd0, a_out_data},  32'hF0);
        chk("bp_ovf",   {31'd0, a_out_ovf},   32'd0);
        a_in_data = 3'd2;
        #1;
        chk("bp_in_ready_lo", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk("bp_hold_valid", {31'd0, a_out_valid}, 32'd1);
        chk("bp_hold_data",  {24'd0, a_out_data},  32'hF0);
        a_out_ready = 1'b1;
        #1;
        chk("bp_in_ready_hi", {31'd0, a_in_ready}, 32'd1);
        tick();
        chk("bp_accept", {31'd0, a_out_valid}, 32'd0);
        a_in_data = 3'd1;
        tick();
        tick();
        chk("bp_cnt1_pending", {31'd0, a_out_valid}, 32'd0);
        tick();
        chk("bp_next_valid", {31'd0, a_out_valid}, 32'd1);
        chk("bp_next_data",  {24'd0, a_out_data},  32'h05);

        // Narrow accumulator: 3 x4 overflows 4-bit signed range.
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 3'd3;
        tick(); tick(); tick(); tick();
        chk("nw_valid", {31'd0, b_out_valid}, 32'd1);
`ifdef SINT_ACC_SAT_EN
        chk("nw_data",  {28'd0, b_out_data},  32'h7);
`else
        chk("nw_data",  {28'd0, b_out_data},  32'hC);
`endif
        chk("nw_ovf",   {31'd0, b_out_ovf},   32'd1);
        b_in_data = 3'd1;
        tick(); tick(); tick(); tick();
        chk("nw2_valid", {31'd0, b_out_valid}, 32'd1);
        chk("nw2_data",  {28'd0, b_out_data},  32'h4);
        chk("nw2_ovf",   {31'd0, b_out_ovf},   32'd0);
        b_in_valid = 1'b0;

        // COUNT=1: every sample emerges once, in order, under toggling ready.
        samp[0] = 8'h01; samp[1] = 8'h02; samp[2] = 8'h03; samp[3] = 8'hFF;
        samp[4] = 8'hFE; samp[5] = 8'hFC; samp[6] = 8'h00; samp[7] = 8'h01;
        k    = 0;
        nout = 0;
        cyc  = 0;
        while (nout < 8 && cyc < 40) begin
            c_out_ready = (cyc % 2) == 0;
            c_in_valid  = (k < 8);
            c_in_data   = (k < 8) ? samp[k][2:0] : 3'd0;
            #1;
            if (c_out_valid && c_out_ready) begin
                chk($sformatf("c1_out%0d", nout), {24'd0, c_out_data},
                    {24'd0, samp[nout]});
                nout++;
            end
            took = c_in_valid && c_in_ready;
            tick();
            if (took) k++;
            cyc++;
        end
        chk("c1_count", nout, 32'd8);
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;

        // Reset mid-window discards the partial sum.
        a_in_valid = 1'b0;   tick();
        a_in_valid = 1'b1;
        a_in_data  = 3'd3;
        tick(); tick();
        ASYNCRESET = 1'b1;
        #1;
        chk("mr_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mr_ready", {31'd0, a_in_ready},  32'd1);
        chk("mr_data",  {24'd0, a_out_data},  32'h00);
        tick();
        ASYNCRESET = 1'b0;
        a_in_data = 3'd1;    tick();
        tick();
        tick();
        a_in_data = 3'b111;  tick();
        chk("mr_win_valid", {31'd0, a_out_valid}, 32'd1);
        chk("mr_win_data",  {24'd0, a_out_data},  32'h02);
        chk("mr_win_ovf",   {31'd0, a_out_ovf},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
